// File: rtl/fp_norm_round.sv
// Normalize/round back end of the sequential binary32 multiplier: walks the raw
// product into place one shift per cycle, rounds to nearest-even and packs the result.
module fp_norm_round #(
   parameter int EXP_W   = 10,
   parameter int MAN_W   = 48,
   parameter int MAX_RSH = 26
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_sign,
   input  logic signed [EXP_W-1:0] i_exp,
   input  logic [MAN_W-1:0]        i_mant,
   input  logic [1:0]              i_class,
   output logic [31:0]             o_res,
   output logic                    o_valid,
   output logic                    o_busy
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   localparam logic signed [EXP_W-1:0] EXP_ONE      = EXP_W'(1);
   localparam logic signed [EXP_W-1:0] EXP_COLLAPSE = EXP_W'(1 - MAX_RSH);
   localparam logic signed [EXP_W:0]   EXP_INF      = (EXP_W+1)'(255);

   state_t                  state;
   logic                    sign;
   logic signed [EXP_W-1:0] exp;
   logic [MAN_W-1:0]        mant;
   logic                    sticky;

   logic [22:0]             frac;
   logic                    guardBit;
   logic                    stickyAll;
   logic                    roundUp;
   logic [24:0]             roundSum;
   logic signed [EXP_W:0]   expRnd;
   logic                    hiddenRnd;
   logic [22:0]             fracRnd;
   logic [31:0]             packedRes;

   // A carry out of the 24-bit significand bumps the exponent; a subnormal that
   // rounds up into the hidden bit becomes the minimum normal on its own.
   always_comb begin
      frac      = mant[MAN_W-3 -: 23];
      guardBit  = mant[MAN_W-26];
      stickyAll = sticky | (|mant[MAN_W-27:0]);
      roundUp   = guardBit & (stickyAll | frac[0]);
      roundSum  = {1'b0, mant[MAN_W-2], frac} + {24'd0, roundUp};
      expRnd    = {exp[EXP_W-1], exp} + {{EXP_W{1'b0}}, roundSum[24]};
      hiddenRnd = roundSum[24] | roundSum[23];
      fracRnd   = roundSum[24] ? 23'd0 : roundSum[22:0];
      if (expRnd >= EXP_INF)
         packedRes = {sign, 8'hFF, 23'd0};
      else
         packedRes = {sign, hiddenRnd ? expRnd[7:0] : 8'd0, fracRnd};
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state   <= IDLE;
         sign    <= 1'b0;
         exp     <= '0;
         mant    <= '0;
         sticky  <= 1'b0;
         o_res   <= '0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_valid <= 1'b0;
               // o_busy is still high during the o_valid cycle, which blocks a restart there
               if (i_start && !o_busy) begin
                  sign   <= i_sign;
                  exp    <= i_exp;
                  mant   <= i_mant;
                  sticky <= 1'b0;
                  o_busy <= 1'b1;
                  if (i_class == 2'b11) begin
                     o_res <= '1;
                     state <= DONE;
                  end else if (i_class == 2'b10) begin
                     o_res <= {i_sign, 8'hFF, 23'd0};
                     state <= DONE;
                  end else if (i_class == 2'b01 || i_mant == '0) begin
                     o_res <= {i_sign, 31'd0};
                     state <= DONE;
                  end else begin
                     state <= NORM;
                  end
               end else begin
                  o_busy <= 1'b0;
               end
            end
            NORM: begin
               if (exp < EXP_COLLAPSE) begin
                  sticky <= sticky | (|mant);
                  mant   <= '0;
                  exp    <= EXP_ONE;
                  state  <= ROUND;
               end else if (mant[MAN_W-1] || exp < EXP_ONE) begin
                  mant   <= mant >> 1;
                  sticky <= sticky | mant[0];
                  exp    <= exp + EXP_ONE;
               end else if (!mant[MAN_W-2] && exp > EXP_ONE) begin
                  mant <= mant << 1;
                  exp  <= exp - EXP_ONE;
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               o_res <= packedRes;
               state <= DONE;
            end
            DONE: begin
               o_valid <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed plan cases plus random operands
// against an exact round-to-nearest-even reference.
module tb_fp_norm_round;

   logic               clk = 1'b0;
   logic               i_rst = 1'b0;
   logic               i_start = 1'b0;
   logic               i_sign = 1'b0;
   logic signed [9:0]  i_exp = '0;
   logic [47:0]        i_mant = '0;
   logic [1:0]         i_class = 2'b00;
   logic [31:0]        o_res;
   logic               o_valid;
   logic               o_busy;

   int vectors = 0;
   int miscompares = 0;

   fp_norm_round dut (
      .i_clk   (clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_sign  (i_sign),
      .i_exp   (i_exp),
      .i_mant  (i_mant),
      .i_class (i_class),
      .o_res   (o_res),
      .o_valid (o_valid),
      .o_busy  (o_busy)
   );

   always #5 clk = ~clk;

   // Exact value is mant * 2^(exp-173); round it to a binary32 grid with plain integers.
   function automatic logic [31:0] model(input logic s, input int e, input logic [47:0] m,
                                         input logic [1:0] c);
      int p, bigE, sh, eb;
      longint unsigned mm, n, rem, half;
      logic [7:0] field;
      if (c == 2'b11) return 32'hFFFFFFFF;
      if (c == 2'b10) return {s, 8'hFF, 23'd0};
      if (c == 2'b01 || m == 48'd0) return {s, 31'd0};
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      bigE = p + e - 46;
      sh   = (bigE >= 1) ? p - 23 : p - 23 + 1 - bigE;
      eb   = (bigE >= 1) ? bigE : 1;
      mm   = 64'(m);
      if (sh <= 0) n = mm << (-sh);
      else if (sh > 48) n = 0;
      else begin
         n    = mm >> sh;
         rem  = mm & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && n[0])) n = n + 1;
      end
      if (n >= (64'd1 << 24)) begin
         n  = n >> 1;
         eb = eb + 1;
      end
      if (eb >= 255) return {s, 8'hFF, 23'd0};
      field = (n < (64'd1 << 23)) ? 8'd0 : eb[7:0];
      return {s, field, n[22:0]};
   endfunction

   // Issue one operation once the block is idle; lat = edges until o_valid, -1 on timeout.
   task automatic run_op(input logic s, input int e, input logic [47:0] m, input logic [1:0] c,
                         output logic [31:0] res, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (o_busy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      i_sign  = s;
      i_exp   = e[9:0];
      i_mant  = m;
      i_class = c;
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      lat = 0;
      while (!o_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!o_valid) lat = -1;
      res = o_res;
   endtask

   task automatic test_reset();
      i_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (o_res !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_res got %h want 00000000", o_res);
      end
      vectors++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags got valid=%b busy=%b want 0 0", o_valid, o_busy);
      end
      @(negedge clk);
      i_rst = 1'b1;
   endtask

   task automatic test_directed();
      logic        ts[11];
      int          te[11];
      logic [47:0] tm[11];
      logic [1:0]  tc[11];
      logic [31:0] tr[11];
      int          tl[11];
      logic [31:0] res;
      int          lat;
      ts = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      te = '{125, 127, 127, 127, 127, 254, -1, -100, 0, 0, 0};
      tm = '{48'h4000_0000_0000, 48'h9000_0000_0000, 48'h4000_0040_0000, 48'h4000_00C0_0000,
             48'h4000_0040_0001, 48'hC000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
             48'h1234_5678_9ABC, 48'h1, 48'h1};
      tc = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 1};
      tr = '{32'hBE800000, 32'h40100000, 32'h3F800000, 32'h3F800002, 32'h3F800001,
             32'h7F800000, 32'h00200000, 32'h00000000, 32'hFFFFFFFF, 32'hFF800000,
             32'h80000000};
      tl = '{3, 4, 3, 3, 3, 4, 5, 3, 1, 1, 1};
      for (int i = 0; i < 11; i++) begin
         run_op(ts[i], te[i], tm[i], tc[i], res, lat);
         vectors++;
         if (res !== tr[i]) begin
            miscompares++;
            $display("[TB] FAIL directed_res[%0d] got %h want %h", i, res, tr[i]);
         end
         vectors++;
         if (lat != tl[i]) begin
            miscompares++;
            $display("[TB] FAIL directed_lat[%0d] got %0d want %0d", i, lat, tl[i]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int pulses;
      pulses = 0;
      @(negedge clk);
      while (o_busy) @(negedge clk);
      i_sign = 1'b0; i_exp = 10'sd127; i_mant = 48'h9000_0000_0000; i_class = 2'b00;
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      if (o_valid) pulses++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         i_class = 2'b11;
         i_start = 1'b1;
         @(posedge clk);
         #1 i_start = 1'b0;
         if (o_valid) pulses++;
      end
      i_class = 2'b00;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1 if (o_valid) pulses++;
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("[TB] FAIL busy_pulses got %0d want 1", pulses);
      end
      vectors++;
      if (o_res !== 32'h40100000) begin
         miscompares++;
         $display("[TB] FAIL busy_res got %h want 40100000", o_res);
      end
   endtask

   task automatic test_reset_midop();
      int          pulses;
      logic [31:0] res;
      int          lat;
      pulses = 0;
      @(negedge clk);
      while (o_busy) @(negedge clk);
      i_sign = 1'b0; i_exp = 10'sd300; i_mant = 48'h1; i_class = 2'b00;
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      i_rst = 1'b0;
      #1;
      vectors++;
      if (o_res !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL midrst_res got %h want 00000000", o_res);
      end
      vectors++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrst_flags got busy=%b valid=%b want 0 0", o_busy, o_valid);
      end
      @(negedge clk);
      i_rst = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1 if (o_valid) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("[TB] FAIL midrst_pulses got %0d want 0", pulses);
      end
      run_op(1'b1, 125, 48'h4000_0000_0000, 2'b00, res, lat);
      vectors++;
      if (res !== 32'hBE800000 || lat != 3) begin
         miscompares++;
         $display("[TB] FAIL midrst_next got %h lat %0d want BE800000 lat 3", res, lat);
      end
   endtask

   task automatic test_random();
      logic        s;
      int          e;
      logic [47:0] m;
      logic [1:0]  c;
      int          k;
      logic [31:0] res, want;
      int          lat;
      for (int i = 0; i < 200; i++) begin
         s = 1'($urandom);
         e = int'($urandom_range(450, 0)) - 150;
         m = {16'($urandom), 32'($urandom)} >> $urandom_range(47, 0);
         if ($urandom_range(19, 0) == 0) m = 48'd0;
         k = int'($urandom_range(9, 0));
         c = (k < 7) ? 2'b00 : (k == 7) ? 2'b01 : (k == 8) ? 2'b10 : 2'b11;
         want = model(s, e, m, c);
         run_op(s, e, m, c, res, lat);
         vectors++;
         if (lat < 0 || res !== want) begin
            miscompares++;
            $display("[TB] FAIL random[%0d] s=%b e=%0d m=%h c=%0d got %h lat %0d want %h",
                     i, s, e, m, c, res, lat, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Downstream stage of the sequential single-precision floating-point multiplier.
- Consumes the multiplier's raw result: sign, unbiased-sum exponent, 48-bit mantissa product and operand class.
- Normalizes the result iteratively, one shift per cycle, including gradual underflow to subnormal.
- Rounds to nearest-even and packs an IEEE-754 binary32 word, with NaN/Inf/zero handling and a start/valid handshake.

Parameters:
- EXP_W, 10, width of the signed working exponent (two's complement).
- MAN_W, 48, width of the raw mantissa product; bit MAN_W-2 is the hidden-bit position.
- MAX_RSH, 26, number of denormalizing right shifts beyond which the mantissa collapses into sticky.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle request; sampled only when o_busy=0.
- i_sign  in  1  result sign.
- i_exp  in  EXP_W  signed biased exponent. Value = (-1)^s * mant/2^46 * 2^(exp-127).
- i_mant  in  MAN_W  raw product; bits [47:46] form the integer part.
- i_class  in  2  00 finite, 01 zero, 10 infinity, 11 NaN.
- o_res  out  32  packed binary32 result; held until the next result.
- o_valid  out  1  one-cycle pulse when o_res is updated.
- o_busy  out  1  high from acceptance until the cycle o_valid is high, inclusive.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE, o_res=0, o_valid=0, o_busy=0, all internal registers 0. Reset mid-operation abandons the operation; no o_valid is produced.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - i_start=1 at edge k: latch all inputs, clear sticky, set o_busy=1.
  - class 11 -> o_res=32'hFFFFFFFF.
  - class 10 -> {s,8'hFF,23'h0}.
  - class 01, or finite with mant==0 -> {s,31'h0}.
  - All three special cases load o_res at edge k and go to DONE.
  - Otherwise go to NORM.
- NORM, one action per cycle, in priority order:
  - (a) exp < 1-MAX_RSH: sticky|=|mant, mant=0, exp=1, go to ROUND.
  - (b) mant[47]=1: mant>>=1, sticky|=shifted-out bit, exp+=1.
  - (c) exp<1: mant>>=1 with sticky, exp+=1.
  - (d) mant[46]=0 and exp>1: mant<<=1, exp-=1.
  - (e) otherwise go to ROUND.
- ROUND:
  - frac=mant[45:23], guard=mant[22], S=|mant[21:0] | sticky.
  - Round up iff guard & (S | frac[0]).
  - Carry out of frac sets the hidden bit. A normal result renormalizes: exp+=1, frac=0. A subnormal result (hidden=0, exp=1) becomes the minimum normal.
  - Encoded exponent = 0 if hidden bit=0, else exp[7:0].
  - exp>=255 after rounding -> {s,8'hFF,0}.
  - Register o_res, go to DONE.
- DONE: o_valid=1 for exactly one cycle, o_busy=1; next state IDLE.
- Latency, from the edge sampling i_start to the edge after which o_valid is high:
  - special inputs: 1;
  - finite inputs: 2 + number of NORM shift cycles (0..46), plus 1 for the NORM exit cycle.
  - An already-normal input (mant[47:46]=01, 1<=exp<=254) gives 3.
- i_start while o_busy=1 is ignored; there is no queueing.
- A new i_start may be accepted in the cycle after o_valid.
- Sign passes through unchanged for every class except NaN.

Test Plan:
- Normal, no shift: sign=1, exp=125, mant=48'h4000_0000_0000, class 00 -> o_res=32'hBE800000 (-0.25), latency 3, single o_valid pulse.
- Right normalize: sign=0, exp=127, mant=48'h9000_0000_0000 (1.5*1.5) -> 32'h40100000 (2.25), latency 4.
- Round-to-nearest-even:
  - exp=127, mant=48'h4000_0040_0000 (tie, lsb 0) -> 32'h3F800000.
  - mant=48'h4000_00C0_0000 (tie, lsb 1) -> 32'h3F800002.
  - mant=48'h4000_0040_0001 (above half) -> 32'h3F800001.
- Overflow and underflow:
  - exp=254, mant=48'hC000_0000_0000 -> 32'h7F800000.
  - exp=-1, mant=48'h4000_0000_0000 -> 32'h00200000 after 2 right shifts, latency 5.
  - exp=-100 -> 32'h00000000 via collapse.
- Specials:
  - class 11 -> 32'hFFFFFFFF, latency 1.
  - class 10 with sign 1 -> 32'hFF800000.
  - class 01 with sign 1 -> 32'h80000000.
- Control:
  - i_start pulsed while busy leaves the result unchanged and produces one o_valid only.
  - i_rst=0 during NORM -> o_res=0, o_busy=0, no o_valid; the next operation completes correctly.
